// File: rtl/sdram_aref_sched_if.sv
// sdram_aref_sched_if: arbiter <-> auto-refresh scheduler signal bundle
// init_end      arbiter -> sched  SDRAM init complete (level)
// aref_en       arbiter -> sched  refresh grant
// aref_cmd      sched -> arbiter  {cs_n,ras_n,cas_n,we_n}
// aref_ba       sched -> arbiter  bank address
// aref_addr     sched -> arbiter  address bus
// aref_req      sched -> arbiter  refresh requested
// aref_urgent   sched -> arbiter  debt at or above urgency threshold
// aref_end      sched -> arbiter  one-cycle sequence-finished pulse
// aref_debt     sched -> arbiter  outstanding refresh count
// aref_overflow sched -> arbiter  sticky lost-obligation flag
interface sdram_aref_sched_if #(
   parameter int ADDR_W   = 13,
   parameter int MAX_DEBT = 8
);
   logic                              init_end;
   logic                              aref_en;
   logic [3:0]                        aref_cmd;
   logic [1:0]                        aref_ba;
   logic [ADDR_W-1:0]                 aref_addr;
   logic                              aref_req;
   logic                              aref_urgent;
   logic                              aref_end;
   logic [$clog2(MAX_DEBT+1)-1:0]     aref_debt;
   logic                              aref_overflow;
   modport master (
      output init_end, aref_en,
      input  aref_cmd, aref_ba, aref_addr, aref_req, aref_urgent, aref_end, aref_debt, aref_overflow
   );
   modport slave (
      input  init_end, aref_en,
      output aref_cmd, aref_ba, aref_addr, aref_req, aref_urgent, aref_end, aref_debt, aref_overflow
   );
endinterface

// File: rtl/sdram_aref_sched.sv
// sdram_aref_sched: SDRAM auto-refresh scheduler with postponable refresh debt
// clk  in  100 MHz SDRAM clock
// rst  in  synchronous active-high reset
// bus  slave side of sdram_aref_sched_if (grant/init in, command bus and status out)
module sdram_aref_sched #(
   parameter int REF_INTERVAL  = 750,
   parameter int TRP_CLK       = 2,
   parameter int TRFC_CLK      = 7,
   parameter int MAX_DEBT      = 8,
   parameter int MAX_BURST     = 4,
   parameter int URGENT_THRESH = 6,
   parameter int ADDR_W        = 13
) (
   input logic               clk,
   input logic               rst,
   sdram_aref_sched_if.slave bus
);
   localparam int DEBT_W = $clog2(MAX_DEBT + 1);
   localparam int TMR_W  = $clog2(REF_INTERVAL + 1);
   localparam int CNT_W  = $clog2((TRP_CLK > TRFC_CLK ? TRP_CLK : TRFC_CLK) + 1);
   localparam int BST_W  = $clog2(MAX_BURST + 1);
   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PCH  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;
   localparam logic [ADDR_W-1:0] PCH_ADDR = ADDR_W'(1) << 10;
   typedef enum logic [2:0] {IDLE, PCH, TRP, AREF, TRFC, END} state_t;
   state_t              state, state_nxt;
   logic [TMR_W-1:0]    timer;
   logic [DEBT_W-1:0]   debt, debt_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [BST_W-1:0]    bcnt;
   logic [3:0]          cmd;
   logic [1:0]          ba;
   logic [ADDR_W-1:0]   addr;
   logic                ovf, aend, tick, dec, sat, req;
   assign req = bus.init_end && debt != '0 && state == IDLE;
   always_comb begin
      tick     = bus.init_end && timer == TMR_W'(REF_INTERVAL - 1);
      dec      = state == AREF;
      sat      = debt == DEBT_W'(MAX_DEBT);
      debt_nxt = (tick && !dec) ? (sat ? debt : debt + DEBT_W'(1)) :
                 (!tick && dec) ? debt - DEBT_W'(1) : debt;
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = (bus.aref_en && req) ? PCH : IDLE;
         PCH:     state_nxt = TRP;
         TRP:     state_nxt = cnt == CNT_W'(TRP_CLK - 1) ? AREF : TRP;
         AREF:    state_nxt = TRFC;
         // burst continues only while budget remains and debt (including a same-cycle tick) is nonzero
         TRFC:    state_nxt = cnt != CNT_W'(TRFC_CLK - 1) ? TRFC :
                              (bcnt < BST_W'(MAX_BURST) && debt_nxt != '0) ? AREF : END;
         END:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end
   // outputs are registered from the next state so they line up with the state they describe
   always_ff @(posedge clk) begin
      if (rst) begin
         timer <= '0;
         debt  <= '0;
         ovf   <= 1'b0;
         cnt   <= '0;
         bcnt  <= '0;
         cmd   <= CMD_NOP;
         ba    <= 2'b11;
         addr  <= '1;
         aend  <= 1'b0;
      end else begin
         timer <= (!bus.init_end || tick) ? '0 : timer + TMR_W'(1);
         debt  <= debt_nxt;
         ovf   <= ovf | (tick && !dec && sat);
         cnt   <= (state_nxt != state || state == IDLE) ? '0 : cnt + CNT_W'(1);
         bcnt  <= state == END ? '0 : dec ? bcnt + BST_W'(1) : bcnt;
         cmd   <= state_nxt == PCH ? CMD_PCH : state_nxt == AREF ? CMD_AREF : CMD_NOP;
         ba    <= state_nxt == PCH ? 2'b00 : 2'b11;
         addr  <= state_nxt == PCH ? PCH_ADDR : '1;
         aend  <= state_nxt == END;
      end
   end
   assign bus.aref_cmd      = cmd;
   assign bus.aref_ba       = ba;
   assign bus.aref_addr     = addr;
   assign bus.aref_req      = req;
   assign bus.aref_urgent   = debt >= DEBT_W'(URGENT_THRESH);
   assign bus.aref_end      = aend;
   assign bus.aref_debt     = debt;
   assign bus.aref_overflow = ovf;
endmodule

// File: tb/tb_sdram_aref_sched.sv
// tb_sdram_aref_sched: randomized and directed bench against a schedule-arithmetic model
module tb_sdram_aref_sched;
   localparam int RI = 750, TRP = 2, TRFC = 7, MD = 8, MB = 4, UT = 6, AW = 13;
   localparam int P = 2 + TRP;
   localparam int S = 1 + TRFC;
   localparam int NOP = 4'b0111, PCHC = 4'b0010, AREFC = 4'b0001;
   logic clk = 1'b0, rst = 1'b1, aref_en = 1'b0, init_end = 1'b0;
   int n_chk = 0, n_err = 0;
   int m_timer = 0, m_debt = 0, pos = 0, n_ar = 0, end_pos = 0;
   bit m_ovf = 0, in_seq = 0;
   sdram_aref_sched_if #(.ADDR_W(AW), .MAX_DEBT(MD)) bus ();
   assign bus.aref_en  = aref_en;
   assign bus.init_end = init_end;
   sdram_aref_sched dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic bit is_aref(input int p);
      return p >= P && (p - P) % S == 0 && p < end_pos;
   endfunction
   // model: sequence position since grant; PCH at 1, AREFs every S cycles from P, END one after the deciding TRFC cycle
   task automatic model_step();
      int nd;
      bit tk, ar;
      if (rst) begin
         m_timer = 0; m_debt = 0; m_ovf = 0; in_seq = 0; pos = 0; n_ar = 0; end_pos = 0;
      end else begin
         tk = init_end && m_timer == RI - 1;
         ar = in_seq && is_aref(pos);
         nd = m_debt + int'(tk) - int'(ar);
         if (nd > MD) begin nd = MD; m_ovf = 1; end
         m_timer = (!init_end || tk) ? 0 : m_timer + 1;
         if (!in_seq) begin
            if (aref_en && init_end && m_debt != 0) begin in_seq = 1; pos = 1; n_ar = 0; end_pos = 1 << 30; end
         end else if (pos == end_pos) in_seq = 0;
         else begin
            if (ar) n_ar++;
            if (pos >= P && (pos - P) % S == S - 1 && !(n_ar < MB && nd != 0)) end_pos = pos + 1;
            pos++;
         end
         m_debt = nd;
      end
   endtask
   task automatic compare_all();
      int e_cmd;
      logic [AW-1:0] ones;
      ones = '1;
      e_cmd = !in_seq ? NOP : pos == 1 ? PCHC : is_aref(pos) ? AREFC : NOP;
      check("cmd", bus.aref_cmd, e_cmd);
      if (e_cmd == PCHC) check("pch_a10", bus.aref_addr[10], 1);
      else begin
         check("ba", bus.aref_ba, 3);
         check("addr", bus.aref_addr, ones);
      end
      check("req", bus.aref_req, init_end && m_debt != 0 && !in_seq);
      check("urgent", bus.aref_urgent, m_debt >= UT);
      check("end", bus.aref_end, in_seq && pos == end_pos);
      check("debt", bus.aref_debt, m_debt);
      check("overflow", bus.aref_overflow, m_ovf);
   endtask
   task automatic cyc(input bit en, input bit ie, input bit r);
      aref_en = en; init_end = ie; rst = r;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask
   task automatic wait_debt(input int target, input int bound);
      for (int k = 0; k < bound && m_debt != target; k++) cyc(0, 1, 0);
      check("wait_debt", bus.aref_debt, target);
   endtask
   initial begin
      int na;
      bit ie, en;
      for (int i = 0; i < 3; i++) cyc(0, 0, 1);
      check("rst_cmd", bus.aref_cmd, NOP);
      check("rst_debt", bus.aref_debt, 0);
      for (int i = 0; i < 6; i++) cyc(0, 0, 0);
      for (int i = 1; i <= 750; i++) begin
         cyc(0, 1, 0);
         if (i == 749) check("pre_tick_debt", bus.aref_debt, 0);
         if (i == 750) begin
            check("first_tick_debt", bus.aref_debt, 1);
            check("first_tick_req", bus.aref_req, 1);
         end
      end
      cyc(1, 1, 0);
      check("grant_pch", bus.aref_cmd, PCHC);
      check("grant_req_low", bus.aref_req, 0);
      for (int i = 2; i <= 13; i++) begin
         cyc(0, 1, 0);
         if (i == 4) check("single_aref", bus.aref_cmd, AREFC);
         if (i == 5) check("single_debt0", bus.aref_debt, 0);
         if (i == 12) check("single_end", bus.aref_end, 1);
      end
      wait_debt(6, 6 * RI + 50);
      check("urgent_at6", bus.aref_urgent, 1);
      cyc(1, 1, 0);
      na = 0;
      for (int i = 2; i <= 37; i++) begin
         cyc(0, 1, 0);
         if (bus.aref_cmd == 4'b0001) na++;
         if (i == 36) check("burst_end", bus.aref_end, 1);
         if (i == 37) begin
            check("burst_req", bus.aref_req, 1);
            check("burst_debt", bus.aref_debt, 2);
         end
      end
      check("burst_count", na, 4);
      wait_debt(8, 6 * RI + 50);
      for (int k = 0; k < RI + 10 && !m_ovf; k++) cyc(0, 1, 0);
      check("ovf_set", bus.aref_overflow, 1);
      check("ovf_debt_sat", bus.aref_debt, 8);
      for (int k = 0; k < 400 && (m_debt != 0 || in_seq); k++) cyc(1, 1, 0);
      check("drain_debt", bus.aref_debt, 0);
      check("ovf_sticky", bus.aref_overflow, 1);
      wait_debt(1, RI + 50);
      for (int k = 0; k < RI + 10 && m_timer != RI - 5; k++) cyc(0, 1, 0);
      cyc(1, 1, 0);
      for (int i = 2; i <= 21; i++) begin
         cyc(i < 3, 1, 0);
         if (i == 4) check("coin_aref", bus.aref_cmd, AREFC);
         if (i == 5) check("coin_debt_hold", bus.aref_debt, 1);
         if (i == 12) check("coin_aref2", bus.aref_cmd, AREFC);
         if (i == 20) check("coin_end", bus.aref_end, 1);
      end
      wait_debt(1, RI + 50);
      cyc(1, 1, 0);
      for (int i = 2; i <= 6; i++) cyc(0, 1, 0);
      cyc(0, 1, 1);
      check("rst_trfc_cmd", bus.aref_cmd, NOP);
      check("rst_trfc_debt", bus.aref_debt, 0);
      check("rst_trfc_end", bus.aref_end, 0);
      check("rst_trfc_ovf", bus.aref_overflow, 0);
      check("rst_trfc_req", bus.aref_req, 0);
      ie = 1;
      for (int b = 0; b < 12; b++) begin
         int p;
         p = $urandom_range(0, 2);
         for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 999) == 0) ie = ~ie;
            if (!ie && $urandom_range(0, 49) == 0) ie = 1;
            en = p == 0 ? 1'b0 : p == 1 ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
            cyc(en, ie, $urandom_range(0, 9999) == 0);
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
